// File: rtl/avalon_master_exram_copy_8bit.sv
// Avalon-MM 8-bit master that copies a byte block inside the external RAM:
// read one byte, wait a fixed latency, write it back elsewhere, repeat.
module avalon_master_exram_copy_8bit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic [15:0] byte_count,
  output logic        out_avs_chipselect_n,
  output logic        out_avs_read_n,
  output logic        out_avs_write_n,
  output logic [15:0] out_avs_address,
  output logic [7:0]  out_avs_writedata,
  input  logic [7:0]  in_avs_readdata
);

  // Bus handshake: no waitrequest exists, so a strobe held low for one cycle
  // with chipselect_n low is one complete transfer; read data is sampled on the
  // edge that ends the last WAIT cycle.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 1);

  logic [2:0]  state;
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [15:0] len_q;
  logic [15:0] idx;
  logic [3:0]  wait_cnt;
  logic [15:0] idx_next;

  assign idx_next = idx + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      src_q                <= 16'd0;
      dst_q                <= 16'd0;
      len_q                <= 16'd0;
      idx                  <= 16'd0;
      wait_cnt             <= 4'd0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      byte_count           <= 16'd0;
      out_avs_chipselect_n <= 1'b1;
      out_avs_read_n       <= 1'b1;
      out_avs_write_n      <= 1'b1;
      out_avs_address      <= 16'd0;
      out_avs_writedata    <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            len_q      <= len;
            idx        <= 16'd0;
            byte_count <= 16'd0;
            busy       <= 1'b1;
            if (len == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state                <= S_RD;
              out_avs_chipselect_n <= 1'b0;
              out_avs_read_n       <= 1'b0;
              out_avs_address      <= src_addr;
            end
          end
        end
        S_RD: begin
          state                <= S_WAIT;
          out_avs_chipselect_n <= 1'b1;
          out_avs_read_n       <= 1'b1;
          wait_cnt             <= 4'd0;
        end
        S_WAIT: begin
          // Address still holds src+i, so the RAM keeps presenting the byte.
          if (wait_cnt == WAIT_LAST) begin
            state                <= S_WR;
            out_avs_chipselect_n <= 1'b0;
            out_avs_write_n      <= 1'b0;
            out_avs_address      <= dst_q + idx;
            out_avs_writedata    <= in_avs_readdata;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_WR: begin
          idx             <= idx_next;
          byte_count      <= byte_count + 16'd1;
          out_avs_write_n <= 1'b1;
          if (idx_next == len_q) begin
            state                <= S_DONE;
            done                 <= 1'b1;
            out_avs_chipselect_n <= 1'b1;
          end else begin
            state                <= S_RD;
            out_avs_chipselect_n <= 1'b0;
            out_avs_read_n       <= 1'b0;
            out_avs_address      <= src_q + idx_next;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state                <= S_IDLE;
          busy                 <= 1'b0;
          out_avs_chipselect_n <= 1'b1;
          out_avs_read_n       <= 1'b1;
          out_avs_write_n      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_master_exram_copy_8bit.sv
// Directed bench for the exram copy master: RAM models on the Avalon side,
// cycle-exact done timing, address wrap, ignored restart, reset abort, RL=3.
module tb_avalon_master_exram_copy_8bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, start3;
  logic [15:0] src1, dst1, len1, src3, dst3, len3;
  logic        busy1, done1, cs1, rd1, wr1;
  logic        busy3, done3, cs3, rd3, wr3;
  logic [15:0] bc1, addr1, bc3, addr3;
  logic [7:0]  wd1, rdata1, wd3, rdata3;

  logic [7:0]  ram1 [0:65535];
  logic [7:0]  ram3 [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] rd_log1[$];
  logic [15:0] wr_log1[$];
  int rd_cnt3, wr_cnt3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  avalon_master_exram_copy_8bit #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .src_addr(src1), .dst_addr(dst1), .len(len1),
    .busy(busy1), .done(done1), .byte_count(bc1),
    .out_avs_chipselect_n(cs1), .out_avs_read_n(rd1), .out_avs_write_n(wr1),
    .out_avs_address(addr1), .out_avs_writedata(wd1), .in_avs_readdata(rdata1)
  );

  avalon_master_exram_copy_8bit #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .src_addr(src3), .dst_addr(dst3), .len(len3),
    .busy(busy3), .done(done3), .byte_count(bc3),
    .out_avs_chipselect_n(cs3), .out_avs_read_n(rd3), .out_avs_write_n(wr3),
    .out_avs_address(addr3), .out_avs_writedata(wd3), .in_avs_readdata(rdata3)
  );

  assign rdata1 = ram1[addr1];
  assign rdata3 = ram3[addr3];

  always @(posedge clk) begin
    if (!cs1 && !wr1) ram1[addr1] <= wd1;
    if (!cs3 && !wr3) ram3[addr3] <= wd3;
  end

  // Bus monitors: log transfers and check strobe exclusivity mid-cycle
  always @(negedge clk) begin
    if (!cs1 && !rd1) rd_log1.push_back(addr1);
    if (!cs1 && !wr1) wr_log1.push_back(addr1);
    if (!cs1 || !rd1 || !wr1) check("strobes1", {cs1, rd1 ^ wr1}, 2'b01);
    if (!cs3 && !rd3) rd_cnt3++;
    if (!cs3 && !wr3) wr_cnt3++;
    if (!cs3 || !rd3 || !wr3) check("strobes3", {cs3, rd3 ^ wr3}, 2'b01);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a copy on dut1 and step until done; optionally re-pulse start.
  task automatic run1(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                      input int budget, input int re_cyc, input logic [15:0] re_src,
                      output int done_cyc, output int busy_gaps);
    rd_log1.delete();
    wr_log1.delete();
    src1 = s; dst1 = d; len1 = l; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    done_cyc = -1;
    busy_gaps = 0;
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      if (!busy1) busy_gaps++;
      if (done1) done_cyc = c;
      if (c == re_cyc) begin
        start1 = 1'b1;
        src1 = re_src;
      end else begin
        start1 = 1'b0;
      end
      if (done_cyc < 0) tick();
    end
    start1 = 1'b0;
  endtask

  int dc, bg, seen;

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; src1 = 16'd0; dst1 = 16'd0; len1 = 16'd0;
    start3 = 1'b0; src3 = 16'd0; dst3 = 16'd0; len3 = 16'd0;
    rd_cnt3 = 0; wr_cnt3 = 0;
    for (int a = 0; a < 65536; a++) begin
      ram1[a] <= 8'h00;
      ram3[a] <= 8'h00;
    end
    tick();
    tick();
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_bc", bc1, 16'h0000);
    check("rst_cs", cs1, 1'b1);
    check("rst_rd", rd1, 1'b1);
    check("rst_wr", wr1, 1'b1);
    check("rst_addr", addr1, 16'h0000);
    check("rst_wd", wd1, 8'h00);
    check("rst_busy3", busy3, 1'b0);
    check("rst_cs3", cs3, 1'b1);
    rst_n = 1'b1;
    tick();

    // Basic 4-byte copy, RL=1: done in cycle 13
    ram1[16'h0100] <= 8'hA1; ram1[16'h0101] <= 8'hB2;
    ram1[16'h0102] <= 8'hC3; ram1[16'h0103] <= 8'hD4;
    run1(16'h0100, 16'h0200, 16'd4, 40, 0, 16'h0000, dc, bg);
    check("t1_done_cyc", dc, 13);
    check("t1_busy_gaps", bg, 0);
    check("t1_bc", bc1, 16'd4);
    check("t1_nrd", rd_log1.size(), 4);
    check("t1_nwr", wr_log1.size(), 4);
    if (rd_log1.size() == 4) check("t1_rd3", rd_log1[3], 16'h0103);
    if (wr_log1.size() == 4) check("t1_wr0", wr_log1[0], 16'h0200);
    check("t1_m0", ram1[16'h0200], 8'hA1);
    check("t1_m1", ram1[16'h0201], 8'hB2);
    check("t1_m2", ram1[16'h0202], 8'hC3);
    check("t1_m3", ram1[16'h0203], 8'hD4);
    tick();
    check("t1_busy_after", busy1, 1'b0);
    check("t1_done_after", done1, 1'b0);
    check("t1_bc_hold", bc1, 16'd4);
    check("t1_addr_hold", addr1, 16'h0203);
    check("t1_wd_hold", wd1, 8'hD4);

    // len=0: done in cycle 1, no bus cycles, byte_count cleared
    run1(16'h0100, 16'h0200, 16'd0, 10, 0, 16'h0000, dc, bg);
    check("t2_done_cyc", dc, 1);
    check("t2_busy_gaps", bg, 0);
    check("t2_nrd", rd_log1.size(), 0);
    check("t2_nwr", wr_log1.size(), 0);
    check("t2_bc", bc1, 16'd0);
    tick();

    // start held through DONE: accepted again only in the following IDLE cycle
    len1 = 16'd0; start1 = 1'b1;
    tick();
    check("hold_done_c1", done1, 1'b1);
    tick();
    check("hold_done_c2", done1, 1'b0);
    check("hold_busy_c2", busy1, 1'b0);
    tick();
    check("hold_done_c3", done1, 1'b1);
    start1 = 1'b0;
    tick();
    tick();

    // Address wrap on both source and destination
    ram1[16'hFFFE] <= 8'h5A; ram1[16'hFFFF] <= 8'h6B; ram1[16'h0000] <= 8'h7C;
    run1(16'hFFFE, 16'h7FFF, 16'd3, 40, 0, 16'h0000, dc, bg);
    check("t3_done_cyc", dc, 10);
    check("t3_nrd", rd_log1.size(), 3);
    check("t3_nwr", wr_log1.size(), 3);
    if (rd_log1.size() == 3) begin
      check("t3_rd1", rd_log1[1], 16'hFFFF);
      check("t3_rd2", rd_log1[2], 16'h0000);
    end
    if (wr_log1.size() == 3) begin
      check("t3_wr1", wr_log1[1], 16'h8000);
      check("t3_wr2", wr_log1[2], 16'h8001);
    end
    check("t3_m0", ram1[16'h7FFF], 8'h5A);
    check("t3_m2", ram1[16'h8001], 8'h7C);
    tick();

    // start re-pulsed in cycle 5 with another src: must be ignored
    ram1[16'h0600] <= 8'h10; ram1[16'h0601] <= 8'h20;
    ram1[16'h0602] <= 8'h30; ram1[16'h0603] <= 8'h40;
    ram1[16'h0900] <= 8'h99; ram1[16'h0901] <= 8'h99;
    ram1[16'h0902] <= 8'h99; ram1[16'h0903] <= 8'h99;
    run1(16'h0600, 16'h0700, 16'd4, 40, 5, 16'h0900, dc, bg);
    check("t4_done_cyc", dc, 13);
    check("t4_bc", bc1, 16'd4);
    if (rd_log1.size() == 4) check("t4_rd2", rd_log1[2], 16'h0602);
    check("t4_m1", ram1[16'h0701], 8'h20);
    check("t4_m3", ram1[16'h0703], 8'h40);
    tick();
    tick();
    check("t4_idle", busy1, 1'b0);

    // Reset during WR of the second byte aborts the copy
    ram1[16'h0400] <= 8'h11; ram1[16'h0401] <= 8'h22;
    ram1[16'h0402] <= 8'h33; ram1[16'h0403] <= 8'h44;
    src1 = 16'h0400; dst1 = 16'h0500; len1 = 16'd4; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("t5_rd_c1", rd1, 1'b0);
    check("t5_addr_c1", addr1, 16'h0400);
    repeat (5) tick();
    check("t5_wr_c6", wr1, 1'b0);
    check("t5_addr_c6", addr1, 16'h0501);
    check("t5_wd_c6", wd1, 8'h22);
    rst_n = 1'b0;
    tick();
    check("t5_cs_rst", cs1, 1'b1);
    check("t5_wr_rst", wr1, 1'b1);
    check("t5_busy_rst", busy1, 1'b0);
    check("t5_bc_rst", bc1, 16'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done1 || !cs1 || busy1) seen++;
    end
    check("t5_no_resume", seen, 0);
    check("t5_m0", ram1[16'h0500], 8'h11);
    check("t5_m2", ram1[16'h0502], 8'h00);

    // RL=3: read data must be sampled at the end of the third WAIT cycle
    ram3[16'h0301] <= 8'hF6;
    rd_cnt3 = 0; wr_cnt3 = 0;
    src3 = 16'h0300; dst3 = 16'h0310; len3 = 16'd2; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    dc = -1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      if (c == 4) ram3[16'h0300] <= 8'hE5;
      if (done3) dc = c;
      if (dc < 0) tick();
    end
    check("t6_done_cyc", dc, 11);
    check("t6_bc", bc3, 16'd2);
    check("t6_m0", ram3[16'h0310], 8'hE5);
    check("t6_m1", ram3[16'h0311], 8'hF6);
    tick();
    check("t6_nrd", rd_cnt3, 2);
    check("t6_nwr", wr_cnt3, 2);
    check("t6_idle", busy3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
